// File: rtl/imem_loader_pkg.sv
// Shared types and default sizes for the instruction-memory loader.
// The default sizes mirror the system-wide IMEM_SIZE / IMEM_ADDR_WIDTH macros.
package imem_loader_pkg;

    localparam int IMEM_SIZE_DEF       = 1024;
    localparam int IMEM_ADDR_WIDTH_DEF = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word packer: byte 0 lands in [31:24], byte 3 in [7:0].
// The word output already includes the byte being accepted this cycle.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data,
    input  logic        accept,
    input  logic        clear,
    output logic [31:0] word,
    output logic        full
);

    logic [31:0] shreg;
    logic [1:0]  cnt;

    always_comb begin
        word = shreg;
        if (accept) begin
            case (cnt)
                2'd0:    word[31:24] = data;
                2'd1:    word[23:16] = data;
                2'd2:    word[15:8]  = data;
                default: word[7:0]   = data;
            endcase
        end
    end

    // Unfilled byte lanes stay zero, which gives the padding of a short last word.
    assign full = (cnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= 32'h0;
            cnt   <= 2'd0;
        end else if (clear) begin
            shreg <= 32'h0;
            cnt   <= 2'd0;
        end else if (accept) begin
            shreg <= word;
            cnt   <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader: packs a byte stream into 32-bit words, writes them to the
// instruction memory write port and holds the CPU in reset while loading.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          IMEM_SIZE       = IMEM_SIZE_DEF,
    parameter int          IMEM_ADDR_WIDTH = IMEM_ADDR_WIDTH_DEF,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic [15:0] word_count,
    output logic        err_partial,
    output logic        err_overflow
);

    // Word index must be able to hold the capacity value itself (IMEM_SIZE/4).
    localparam int               IDX_W = IMEM_ADDR_WIDTH - 1;
    localparam logic [IDX_W-1:0] CAP   = IDX_W'(IMEM_SIZE / 4);

    state_t           state, next_state;
    logic [IDX_W-1:0] widx;
    logic             last_seen;
    logic             accept, at_cap, take, word_end, clear;
    logic [31:0]      word;
    logic             full;

    assign at_cap   = (widx == CAP);
    assign accept   = in_valid && in_ready;
    assign take     = accept && !at_cap;
    assign word_end = take && (full || in_last);
    assign clear    = ((state == IDLE) && start) || (state == WRITE);

    imem_word_packer u_packer (
        .clk    (clk),
        .rst_n  (rst_n),
        .data   (in_data),
        .accept (take),
        .clear  (clear),
        .word   (word),
        .full   (full)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (start) next_state = LOAD;
            LOAD: begin
                if (accept) begin
                    if (at_cap) begin
                        if (in_last) next_state = FINISH;
                    end else if (full || in_last) begin
                        next_state = WRITE;
                    end
                end
            end
            WRITE:  next_state = last_seen ? FINISH : LOAD;
            FINISH: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // All handshake and memory-port outputs are registered from next_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            we           <= 1'b0;
            waddr        <= 32'h0;
            wdata        <= 32'h0;
            widx         <= '0;
            last_seen    <= 1'b0;
            err_partial  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state == LOAD);
            cpu_hold <= (next_state == LOAD) || (next_state == WRITE);
            done     <= (next_state == FINISH);
            we       <= word_end;
            if (word_end) begin
                waddr <= BASE_ADDR + 32'({widx, 2'b00});
                wdata <= word;
            end
            if ((state == IDLE) && start) begin
                widx         <= '0;
                last_seen    <= 1'b0;
                err_partial  <= 1'b0;
                err_overflow <= 1'b0;
            end
            if (state == WRITE) widx <= widx + 1'b1;
            if (accept && at_cap) err_overflow <= 1'b1;
            if (take && in_last) begin
                last_seen <= 1'b1;
                if (!full) err_partial <= 1'b1;
            end
        end
    end

    assign word_count = 16'(widx);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader with a 16-byte memory so overflow is reachable.
module tb_imem_loader;

    localparam int CAP_WORDS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready, we, cpu_hold, done, err_partial, err_overflow;
    logic [31:0] waddr, wdata;
    logic [15:0] word_count;

    imem_loader #(
        .IMEM_SIZE       (16),
        .IMEM_ADDR_WIDTH (4),
        .BASE_ADDR       (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .word_count   (word_count),
        .err_partial  (err_partial),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    typedef struct {
        int wc;
        bit ep;
        bit eo;
    } end_t;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    end_t        end_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: the writes and final status a whole byte stream should produce.
    task automatic model_load(input logic [7:0] b[$]);
        int   n;
        end_t e;
        n = b.size();
        for (int w = 0; (w * 4 < n) && (w < CAP_WORDS); w++) begin
            logic [31:0] v;
            v = 32'h0;
            for (int k = 0; k < 4; k++)
                if (w * 4 + k < n) v = v | (32'(b[w*4+k]) << (24 - 8 * k));
            exp_addr_q.push_back(32'(w * 4));
            exp_data_q.push_back(v);
        end
        e.eo = (n > CAP_WORDS * 4);
        e.wc = ((n + 3) / 4 < CAP_WORDS) ? (n + 3) / 4 : CAP_WORDS;
        e.ep = !e.eo && (n % 4 != 0);
        end_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (we) begin
                check("in_ready_low_during_write", {31'h0, in_ready}, 32'h0);
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_write", 32'h1, 32'h0);
                end else begin
                    check("waddr", waddr, exp_addr_q.pop_front());
                    check("wdata", wdata, exp_data_q.pop_front());
                end
            end
            if (done) begin
                done_seen++;
                check("cpu_hold_at_done", {31'h0, cpu_hold}, 32'h0);
                if (end_q.size() == 0) begin
                    check("unexpected_done", 32'h1, 32'h0);
                end else begin
                    end_t e;
                    e = end_q.pop_front();
                    check("word_count", {16'h0, word_count}, 32'(e.wc));
                    check("err_partial", {31'h0, err_partial}, {31'h0, e.ep});
                    check("err_overflow", {31'h0, err_overflow}, {31'h0, e.eo});
                end
            end
        end
    end

    // Entered and left on a negedge; in_ready sampled here decides the next posedge.
    task automatic send_byte(input logic [7:0] d, input bit last, input bit poke);
        bit acc;
        acc = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        start    = poke;
        for (int t = 0; t < 50; t++) begin
            acc = in_ready;
            @(negedge clk);
            start = 1'b0;
            if (acc) break;
        end
        if (!acc) check("handshake_timeout", 32'h0, 32'h1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic begin_load();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cpu_hold_after_start", {31'h0, cpu_hold}, 32'h1);
    endtask

    task automatic run_load(input logic [7:0] b[$], input int poke_idx);
        int d0;
        model_load(b);
        begin_load();
        d0 = done_seen;
        for (int i = 0; i < b.size(); i++)
            send_byte(b[i], i == b.size() - 1, i == poke_idx);
        for (int t = 0; t < 20; t++) begin
            if (done_seen != d0) break;
            @(negedge clk);
        end
        check("done_pulses", 32'(done_seen - d0), 32'h1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [31:0] w0;

        // Reset with a pending byte: everything quiet.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check("rst_we", {31'h0, we}, 32'h0);
        check("rst_waddr", waddr, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        check("rst_cpu_hold", {31'h0, cpu_hold}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_word_count", {16'h0, word_count}, 32'h0);
        check("rst_err_partial", {31'h0, err_partial}, 32'h0);
        check("rst_err_overflow", {31'h0, err_overflow}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_in_ready", {31'h0, in_ready}, 32'h0);
        in_valid = 1'b0;

        q = '{8'h3C, 8'h01, 8'h10, 8'h01, 8'h34, 8'h3D, 8'h00, 8'h04};
        run_load(q, 2);
        q = '{8'hAD, 8'h09};
        run_load(q, -1);
        q = '{8'h5A};
        run_load(q, -1);
        q = {};
        for (int i = 0; i < 20; i++) q.push_back(8'(i + 1));
        run_load(q, 5);

        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 22);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
            run_load(q, $urandom_range(0, 7));
        end

        // Reset mid-load after six bytes: only word 0 reaches memory.
        q = {};
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom_range(0, 255)));
        w0 = {q[0], q[1], q[2], q[3]};
        exp_addr_q.push_back(32'h0);
        exp_data_q.push_back(w0);
        begin_load();
        for (int i = 0; i < 6; i++) send_byte(q[i], 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_cpu_hold", {31'h0, cpu_hold}, 32'h0);
        check("midrst_in_ready", {31'h0, in_ready}, 32'h0);
        check("midrst_we", {31'h0, we}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        check("pending_writes", 32'(exp_addr_q.size()), 32'h0);
        check("pending_dones", 32'(end_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
